// File: rtl/branch_predict_unit_if.sv
// Fetch lookup and execute resolution bundle for branch_predict_unit.
// master: pipeline side; slave: predictor.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  f_pc;
  logic             f_pred_taken;
  logic [XLEN-1:0]  f_pred_target;
  logic             ex_valid;
  logic [1:0]       ex_type;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_imm;
  logic             ex_cond;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output f_pc,
    output ex_valid, ex_type, ex_pc,
    output ex_rs1, ex_imm, ex_cond,
    output ex_pred_taken, ex_pred_target,
    input  f_pred_taken, f_pred_target,
    input  redirect, redirect_pc,
    input  mispredict_cnt
  );

  modport slave (
    input  f_pc,
    input  ex_valid, ex_type, ex_pc,
    input  ex_rs1, ex_imm, ex_cond,
    input  ex_pred_taken, ex_pred_target,
    output f_pred_taken, f_pred_target,
    output redirect, redirect_pc,
    output mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch target generation, direct-mapped BTB with 2-bit counters,
// execute-time mispredict detection, registered redirect and counter.
// Ports: CLK, RST (async, active-high), bus (slave modport).
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic CLK,
  input  logic RST,
  branch_predict_unit_if.slave bus
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = XLEN - IDX_BITS - 2;

  typedef logic [XLEN-1:0]     word_t;
  typedef logic [TAG_BITS-1:0] tag_t;
  typedef logic [IDX_BITS-1:0] idx_t;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] uncond_q;
  logic [1:0]         ctr_q [ENTRIES];
  tag_t               tag_q [ENTRIES];
  word_t              tgt_q [ENTRIES];

  logic [CNT_W-1:0] cnt_q;
  logic             redir_q;
  word_t            redir_pc_q;

  // fetch lookup
  idx_t f_idx;
  tag_t f_tag;
  logic f_hit;
  logic f_take;

  assign f_idx  = bus.f_pc[IDX_BITS+1:2];
  assign f_tag  = bus.f_pc[XLEN-1:IDX_BITS+2];
  assign f_hit  = valid_q[f_idx] &&
                  (tag_q[f_idx] == f_tag);
  assign f_take = f_hit &&
                  (uncond_q[f_idx] || ctr_q[f_idx][1]);

  assign bus.f_pred_taken  = f_take;
  assign bus.f_pred_target = f_take ? tgt_q[f_idx]
                                    : bus.f_pc + word_t'(4);

  // execute resolution
  idx_t  e_idx;
  tag_t  e_tag;
  logic  e_hit;
  logic  is_cf;
  logic  is_uncond;
  word_t jalr_sum;
  word_t ex_tgt;
  logic  ex_taken;
  word_t ex_next;
  logic  mispredict;

  assign e_idx     = bus.ex_pc[IDX_BITS+1:2];
  assign e_tag     = bus.ex_pc[XLEN-1:IDX_BITS+2];
  assign e_hit     = valid_q[e_idx] &&
                     (tag_q[e_idx] == e_tag);
  assign is_cf     = (bus.ex_type != 2'b00);
  assign is_uncond = bus.ex_type[1];
  assign jalr_sum  = bus.ex_rs1 + bus.ex_imm;

  always_comb begin
    ex_tgt   = bus.ex_pc + bus.ex_imm;
    ex_taken = 1'b0;
    unique case (bus.ex_type)
      2'b01: ex_taken = bus.ex_cond;
      2'b10: ex_taken = 1'b1;
      2'b11: begin
        ex_tgt   = {jalr_sum[XLEN-1:1], 1'b0};
        ex_taken = 1'b1;
      end
      default: ex_taken = 1'b0;
    endcase
  end

  assign ex_next = ex_taken ? ex_tgt
                            : bus.ex_pc + word_t'(4);

  assign mispredict = bus.ex_valid && (
    (ex_taken != bus.ex_pred_taken) ||
    (ex_taken && (ex_tgt != bus.ex_pred_target)));

  // BTB control state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q  <= '0;
      uncond_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
    end else if (bus.ex_valid) begin
      if (is_cf) begin
        if (e_hit) begin
          if (ex_taken) begin
            if (ctr_q[e_idx] != 2'b11)
              ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
            uncond_q[e_idx] <= is_uncond;
          end else if (ctr_q[e_idx] != 2'b00) begin
            ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_q[e_idx]  <= 1'b1;
          uncond_q[e_idx] <= is_uncond;
          ctr_q[e_idx]    <= 2'b10;
        end
      end else if (e_hit) begin
        // non-CF slot hitting an entry: alias or stale
        valid_q[e_idx] <= 1'b0;
      end
    end
  end

  // BTB payload; taken CF writes tag and target on hit or allocate
  always_ff @(posedge CLK) begin
    if (bus.ex_valid && is_cf && ex_taken) begin
      tag_q[e_idx] <= e_tag;
      tgt_q[e_idx] <= ex_tgt;
    end
  end

  // redirect and mispredict counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      redir_q <= mispredict;
      if (mispredict) begin
        redir_pc_q <= ex_next;
        if (cnt_q != {CNT_W{1'b1}})
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.redirect       = redir_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.mispredict_cnt = cnt_q;
endmodule
